// File: rtl/pipe_pkg.sv
// Shared definitions for the IF/ID pipeline stage.
//   OPC_W         opcode width taken from the top of each instruction
//   SAT_W         working width of the saturating-increment helper
//   DEFAULT_NOP   default bubble instruction (all zeros)
//   stage_state_e occupancy of the two-entry skid buffer
//   sat_inc       increment that sticks at the all-ones value of a given width
package pipe_pkg;

  localparam int OPC_W = 6;
  localparam int SAT_W = 64;

  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main entry invalid
    ONE   = 2'd1,  // main valid, skid invalid
    FULL  = 2'd2   // main and skid valid
  } stage_state_e;

  // Callers zero-extend a counter to SAT_W bits and cast the result back to
  // their own width; 'width' is that counter width (must be < SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] cnt,
                                               input int unsigned     width);
    logic [SAT_W-1:0] max_val;
    max_val = (SAT_W'(1) << width) - SAT_W'(1);
    return (cnt >= max_val) ? cnt : cnt + SAT_W'(1);
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with a synchronous clear.
//   clk, rst            clock and synchronous active-high reset
//   clear, clear_data   empty the buffer and load clear_data into the main entry
//   in_valid/in_ready   upstream handshake; in_ready is low only when FULL
//   in_data             upstream payload
//   out_valid/out_ready downstream handshake, driven from the main entry only
//   out_data            main-entry payload
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] clear_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              accept;
  logic              take;

  // Both handshake outputs come straight from the state register, so neither
  // side sees a combinational path from the other.
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = m_data_q;

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (clear) begin
      // Any word accepted this cycle is dropped; a concurrent take has already
      // been handed downstream and needs no action here.
      state_d  = EMPTY;
      m_data_d = clear_data;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d  = ONE;
            m_data_d = in_data;
          end
        end
        ONE: begin
          if (accept && take) begin
            m_data_d = in_data;
          end else if (accept) begin
            state_d  = FULL;
            s_data_d = in_data;
          end else if (take) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            state_d  = ONE;
            m_data_d = s_data_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= EMPTY;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
    end
  end

  // NOTE: skid payload has no reset; its contents are only read when FULL.
  always_ff @(posedge clk) begin
    s_data_q <= s_data_d;
  end

endmodule

// File: rtl/if_id_pipe_stage.sv
// IF/ID pipeline stage between fetch and decode.
//   clk, rst                 clock and synchronous active-high reset
//   in_valid/in_ready        fetch handshake (in_ready low while the skid is full)
//   in_instr, in_pcplus4     fetched instruction and its PC+4
//   flush                    kill wrong-path words, leave a NOP bubble
//   out_valid/out_ready      decode handshake
//   out_instr, out_opcode    instruction to decode (NOP when invalid) and its top bits
//   out_pcplus4              PC+4 paired with out_instr
//   flush_cnt, stall_cnt     saturating flush / back-pressure event counters
module if_id_pipe_stage
  import pipe_pkg::*;
#(
  parameter int                 INSTR_W   = 32,
  parameter int                 PC_W      = 32,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP),
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pcplus4,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [OPC_W-1:0]   out_opcode,
  output logic [PC_W-1:0]    out_pcplus4,
  output logic [CNT_W-1:0]   flush_cnt,
  output logic [CNT_W-1:0]   stall_cnt
);

  localparam int DATA_W = INSTR_W + PC_W;

  logic [DATA_W-1:0]  buf_out_data;
  logic [INSTR_W-1:0] m_instr;
  logic [PC_W-1:0]    m_pcplus4;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  // On flush the main entry becomes {NOP, current fetch PC+4}, so decode keeps
  // seeing where fetch is even while the stage is empty.
  pipe_skid_buf #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .clear_data({NOP_INSTR, in_pcplus4}),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_instr, in_pcplus4}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out_data)
  );

  assign {m_instr, m_pcplus4} = buf_out_data;

  // A stale main entry left behind after a take must not reach decode.
  assign out_instr   = out_valid ? m_instr : NOP_INSTR;
  assign out_opcode  = out_instr[INSTR_W-1 -: OPC_W];
  assign out_pcplus4 = m_pcplus4;

  // Main entry valid covers "M or S valid": the skid is never valid alone.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (flush && out_valid) begin
      flush_cnt_d = CNT_W'(sat_inc(SAT_W'(flush_cnt_q), CNT_W));
    end
    if (out_valid && !out_ready) begin
      stall_cnt_d = CNT_W'(sat_inc(SAT_W'(stall_cnt_q), CNT_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign flush_cnt = flush_cnt_q;
  assign stall_cnt = stall_cnt_q;

endmodule
